// File: rtl/sdram_request_arbiter_pkg.sv
// Shared types and constants for the two-requester SDRAM command arbiter.
package sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_READ
  } arb_state_t;

  localparam int unsigned NUM_REQ        = 2;
  localparam int unsigned REQ_REC_WRITER = 0;
  localparam int unsigned REQ_REC_PLAYER = 1;

endpackage

// File: rtl/sdram_request_arbiter_rr_grant2.sv
// Two-input round-robin picker: on contention the requester that did not win last time is chosen.
module rr_grant2
  import sdram_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] rq_valid,
  input  logic               last_grant,
  output logic               grant_valid,
  output logic               grant_idx
);

  always_comb begin
    grant_valid = |rq_valid;
    if (rq_valid == 2'b11) grant_idx = ~last_grant;
    else                   grant_idx = rq_valid[1];
  end

endmodule

// File: rtl/sdram_request_arbiter.sv
// Round-robin sharing of the SDRAM controller command port between the recording writer and playback reader.
module sdram_request_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 25,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned READ_TIMEOUT = 1023
) (
  input  logic               clock_50Mhz,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] rq_valid,
  input  logic [NUM_REQ-1:0] rq_write,
  input  logic [ADDR_W-1:0]  rq_addr0,
  input  logic [ADDR_W-1:0]  rq_addr1,
  input  logic [DATA_W-1:0]  rq_wdata0,
  input  logic [DATA_W-1:0]  rq_wdata1,
  output logic [NUM_REQ-1:0] rq_accept,
  output logic [NUM_REQ-1:0] rq_rvalid,
  output logic [DATA_W-1:0]  rq_rdata,
  input  logic               clear_error,
  output logic               error_timeout,
  output logic               error_stray,
  output logic [ADDR_W-1:0]  sdram_inputAddress,
  output logic [DATA_W-1:0]  sdram_writeData,
  output logic               sdram_isWriting,
  output logic               sdram_inputValid,
  input  logic [DATA_W-1:0]  sdram_readData,
  input  logic               sdram_outputValid,
  input  logic               sdram_recievedCommand,
  input  logic               sdram_isBusy
);

  localparam int unsigned CNT_W = $clog2(READ_TIMEOUT + 1);

  arb_state_t         state, stateNext;
  logic               lastGrant, lastGrantNext;
  logic               owner, ownerNext;
  logic [CNT_W-1:0]   timeoutCount, timeoutCountNext;
  logic               grantValid, grantIdx;

  logic [NUM_REQ-1:0] acceptNext, rvalidNext;
  logic [DATA_W-1:0]  rdataNext;
  logic [ADDR_W-1:0]  addrNext;
  logic [DATA_W-1:0]  wdataNext;
  logic               isWritingNext, inputValidNext;
  logic               timeoutEvent, strayEvent;
  logic               errTimeoutNext, errStrayNext;

  rr_grant2 picker (
    .rq_valid    (rq_valid),
    .last_grant  (lastGrant),
    .grant_valid (grantValid),
    .grant_idx   (grantIdx)
  );

  always_comb begin
    stateNext        = state;
    lastGrantNext    = lastGrant;
    ownerNext        = owner;
    timeoutCountNext = timeoutCount;
    acceptNext       = '0;
    rvalidNext       = '0;
    rdataNext        = rq_rdata;
    addrNext         = sdram_inputAddress;
    wdataNext        = sdram_writeData;
    isWritingNext    = sdram_isWriting;
    inputValidNext   = sdram_inputValid;
    timeoutEvent     = 1'b0;
    strayEvent       = sdram_outputValid && (state != ARB_WAIT_READ);

    case (state)
      ARB_IDLE: begin
        if (!sdram_isBusy && grantValid) begin
          ownerNext      = grantIdx;
          lastGrantNext  = grantIdx;
          addrNext       = grantIdx ? rq_addr1 : rq_addr0;
          wdataNext      = grantIdx ? rq_wdata1 : rq_wdata0;
          isWritingNext  = rq_write[grantIdx];
          inputValidNext = 1'b1;
          stateNext      = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (sdram_recievedCommand) begin
          inputValidNext    = 1'b0;
          acceptNext[owner] = 1'b1;
          timeoutCountNext  = '0;
          stateNext         = sdram_isWriting ? ARB_IDLE : ARB_WAIT_READ;
        end
      end
      ARB_WAIT_READ: begin
        if (sdram_outputValid) begin
          rdataNext         = sdram_readData;
          rvalidNext[owner] = 1'b1;
          stateNext         = ARB_IDLE;
        end else if (timeoutCount + 1'b1 == CNT_W'(READ_TIMEOUT)) begin
          timeoutEvent = 1'b1;
          stateNext    = ARB_IDLE;
        end else begin
          timeoutCountNext = timeoutCount + 1'b1;
        end
      end
      default: stateNext = ARB_IDLE;
    endcase

    // A new error event takes priority over a simultaneous clear
    errTimeoutNext = timeoutEvent ? 1'b1 : (clear_error ? 1'b0 : error_timeout);
    errStrayNext   = strayEvent   ? 1'b1 : (clear_error ? 1'b0 : error_stray);
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ARB_IDLE;
      lastGrant          <= 1'b1;
      owner              <= 1'b0;
      timeoutCount       <= '0;
      rq_accept          <= '0;
      rq_rvalid          <= '0;
      rq_rdata           <= '0;
      error_timeout      <= 1'b0;
      error_stray        <= 1'b0;
      sdram_inputAddress <= '0;
      sdram_writeData    <= '0;
      sdram_isWriting    <= 1'b0;
      sdram_inputValid   <= 1'b0;
    end else begin
      state              <= stateNext;
      lastGrant          <= lastGrantNext;
      owner              <= ownerNext;
      timeoutCount       <= timeoutCountNext;
      rq_accept          <= acceptNext;
      rq_rvalid          <= rvalidNext;
      rq_rdata           <= rdataNext;
      error_timeout      <= errTimeoutNext;
      error_stray        <= errStrayNext;
      sdram_inputAddress <= addrNext;
      sdram_writeData    <= wdataNext;
      sdram_isWriting    <= isWritingNext;
      sdram_inputValid   <= inputValidNext;
    end
  end

endmodule
